// File: rtl/oscill_nios_pio_in_edge.sv
// Avalon-MM input PIO: per-bit synchroniser, optional debounce filter,
// edge capture with interrupt mask and a level IRQ toward the Nios.
module oscill_nios_pio_in_edge #(
    parameter int WIDTH           = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 1,
    parameter int BIT_CLEAR       = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [31:0]       readdata,
    output logic              irq
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_filtered;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edge_capture;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic             w_write;
    logic             w_unused;

    // Upper writedata bits have no register behind them when WIDTH < 32.
    assign w_unused = ^writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_nofilt
            assign w_filtered = w_sync;
        end else begin : g_filt
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            logic [CW-1:0]    r_cnt [WIDTH];
            logic [WIDTH-1:0] r_filt;

            // Filtered bit only moves after N consecutive cycles of disagreement.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_filt <= '0;
                    for (int i = 0; i < WIDTH; i++) begin
                        r_cnt[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (w_sync[i] == r_filt[i]) begin
                            r_cnt[i] <= '0;
                        end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                            r_filt[i] <= w_sync[i];
                            r_cnt[i]  <= '0;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + CW'(1);
                        end
                    end
                end
            end

            assign w_filtered = r_filt;
        end
    endgenerate

    always_comb begin
        w_edge = '0;
        case (EDGE_TYPE)
            0:       w_edge = w_filtered ^ r_prev;
            2:       w_edge = ~w_filtered & r_prev;
            default: w_edge = w_filtered & ~r_prev;
        endcase
    end

    assign w_write = chipselect & ~write_n;

    always_comb begin
        w_clr = '0;
        if (w_write && address == 2'd3) begin
            w_clr = (BIT_CLEAR != 0) ? writedata[WIDTH-1:0] : '1;
        end
    end

    // A new edge in the clearing cycle wins: OR-ing w_edge after the mask.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev         <= '0;
            r_irqmask      <= '0;
            r_edge_capture <= '0;
            readdata       <= '0;
        end else begin
            r_prev         <= w_filtered;
            r_edge_capture <= (r_edge_capture & ~w_clr) | w_edge;
            if (w_write && address == 2'd2) begin
                r_irqmask <= writedata[WIDTH-1:0];
            end
            case (address)
                2'd0:    readdata <= 32'(w_filtered);
                2'd2:    readdata <= 32'(r_irqmask);
                2'd3:    readdata <= 32'(r_edge_capture);
                default: readdata <= '0;
            endcase
        end
    end

    assign irq = |(r_edge_capture & r_irqmask);

endmodule

// File: tb/tb_oscill_nios_pio_in_edge.sv
// Directed bench for oscill_nios_pio_in_edge: three instances cover the
// default build, a 4-cycle debounce build and a falling-edge/clear-all build.
module tb_oscill_nios_pio_in_edge;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic [2:0]  cs;
  logic        write_n;
  logic [31:0] writedata;
  logic [9:0]  in0, in1, in2;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;
  logic [31:0] rdv;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  oscill_nios_pio_in_edge #(.WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0),
                            .EDGE_TYPE(1), .BIT_CLEAR(1)) dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs[0]),
    .write_n(write_n), .writedata(writedata), .in_port(in0),
    .readdata(rd0), .irq(irq0));

  oscill_nios_pio_in_edge #(.WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
                            .EDGE_TYPE(1), .BIT_CLEAR(1)) dut1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs[1]),
    .write_n(write_n), .writedata(writedata), .in_port(in1),
    .readdata(rd1), .irq(irq1));

  oscill_nios_pio_in_edge #(.WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0),
                            .EDGE_TYPE(2), .BIT_CLEAR(0)) dut2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs[2]),
    .write_n(write_n), .writedata(writedata), .in_port(in2),
    .readdata(rd2), .irq(irq2));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 ns after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input int sel, input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    cs        = 3'b001 << sel;
    tick(1);
    write_n   = 1'b1;
    cs        = 3'b000;
  endtask

  task automatic bus_read(input int sel, input logic [1:0] a, output logic [31:0] d);
    address = a;
    tick(1);
    case (sel)
      0:       d = rd0;
      1:       d = rd1;
      default: d = rd2;
    endcase
  endtask

  initial begin
    reset = 1'b1; address = 2'd0; cs = 3'b000; write_n = 1'b1; writedata = '0;
    in0 = 10'h3FF; in1 = 10'h000; in2 = 10'h000;
    tick(3);
    check_eq("reset_readdata", rd0, 32'h0);
    check_eq("reset_irq", {31'b0, irq0}, 32'h0);
    reset = 1'b0;
    tick(5);

    // Power-on: inputs high at release show up as filtered and as rising edges.
    bus_read(0, 2'd0, rdv); check_eq("poweron_filtered", rdv, 32'h3FF);
    bus_read(0, 2'd3, rdv); check_eq("poweron_edges", rdv, 32'h3FF);
    bus_read(0, 2'd1, rdv); check_eq("reserved_addr1", rdv, 32'h0);
    bus_write(0, 2'd3, 32'h3FF);
    bus_read(0, 2'd3, rdv); check_eq("w1c_all", rdv, 32'h0);

    // Falling edges are not captured in rising mode.
    in0 = 10'h000;
    tick(6);
    bus_read(0, 2'd3, rdv); check_eq("falls_ignored", rdv, 32'h0);
    bus_write(0, 2'd2, 32'h001);
    bus_read(0, 2'd2, rdv); check_eq("mask_readback", rdv, 32'h001);

    // Latency: change just after edge k; readdata/irq move at edge k+3.
    address = 2'd0;
    in0 = 10'h001;
    tick(1); check_eq("lat_rd_k1", rd0, 32'h0); check_eq("lat_irq_k1", {31'b0, irq0}, 32'h0);
    tick(1); check_eq("lat_rd_k2", rd0, 32'h0); check_eq("lat_irq_k2", {31'b0, irq0}, 32'h0);
    tick(1); check_eq("lat_rd_k3", rd0, 32'h1); check_eq("lat_irq_k3", {31'b0, irq0}, 32'h1);
    bus_write(0, 2'd3, 32'h001);
    check_eq("irq_clear_bit0", {31'b0, irq0}, 32'h0);

    // IRQ with mask 0x004.
    bus_write(0, 2'd2, 32'h004);
    in0 = 10'h005;
    tick(4);
    check_eq("irq_bit2", {31'b0, irq0}, 32'h1);
    bus_read(0, 2'd3, rdv); check_eq("cap_bit2", rdv, 32'h004);
    bus_write(0, 2'd3, 32'h004);
    check_eq("irq_after_clear", {31'b0, irq0}, 32'h0);
    in0 = 10'h025;
    tick(4);
    bus_read(0, 2'd3, rdv); check_eq("cap_bit5", rdv, 32'h020);
    check_eq("irq_masked_bit5", {31'b0, irq0}, 32'h0);
    bus_write(0, 2'd3, 32'h020);
    bus_read(0, 2'd3, rdv); check_eq("clear_bit5", rdv, 32'h0);

    // Rising edge on bit1 is captured at edge k+3, the same edge the clear lands.
    in0 = 10'h027;
    tick(2);
    bus_write(0, 2'd3, 32'h002);
    bus_read(0, 2'd3, rdv); check_eq("set_beats_clear", rdv, 32'h002);

    // Debounce N=4: 3-cycle pulse filtered out.
    in1 = 10'h001;
    tick(3);
    in1 = 10'h000;
    tick(10);
    bus_read(1, 2'd0, rdv); check_eq("db_glitch_filt", rdv, 32'h0);
    bus_read(1, 2'd3, rdv); check_eq("db_glitch_cap", rdv, 32'h0);

    // Stable high: filtered at edge k+6, readdata at k+7.
    address = 2'd0;
    in1 = 10'h001;
    tick(6); check_eq("db_rd_k6", rd1, 32'h0);
    tick(1); check_eq("db_rd_k7", rd1, 32'h1);
    bus_read(1, 2'd3, rdv); check_eq("db_cap", rdv, 32'h001);

    // Falling-edge mode with clear-all.
    in2 = 10'h00F;
    tick(5);
    bus_read(2, 2'd3, rdv); check_eq("fall_rise_ignored", rdv, 32'h0);
    in2 = 10'h000;
    tick(5);
    bus_read(2, 2'd3, rdv); check_eq("fall_captured", rdv, 32'h00F);
    bus_write(2, 2'd2, 32'h001);
    check_eq("fall_irq", {31'b0, irq2}, 32'h1);
    bus_write(2, 2'd3, 32'h000);
    check_eq("clrall_irq", {31'b0, irq2}, 32'h0);
    bus_read(2, 2'd3, rdv); check_eq("clrall_cap", rdv, 32'h0);
    check_eq("dut1_irq_nomask", {31'b0, irq1}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
